// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM state encoding and default fetch-unit parameters
package fetch_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FQ_DEPTH = 4;
  localparam int DEF_RESET_PC = 0;
  typedef enum logic [1:0] {IDLE, FETCH, STALL} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous first-word-fall-through FIFO of {pc, data} with occupancy count
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AW = DEF_ADDR_WIDTH,
  parameter int DW = 4 * DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [AW-1:0]                push_pc,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic                         valid,
  output logic [AW-1:0]                head_pc,
  output logic [DW-1:0]                head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] pc_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign head_pc = valid ? pc_q[rd_ptr] : '0;
  assign head_data = valid ? data_q[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr] <= push_pc;
        data_q[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with one-cycle memory latency feeding a FWFT fetch queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FQ_DEPTH = DEF_FQ_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fetch_en,
  input  logic                              redirect_valid,
  input  logic [ADDR_WIDTH-1:0]             redirect_pc,
  output logic [ADDR_WIDTH-1:0]             program_counter,
  output logic                              mem_rd_en,
  input  logic [4*DATA_WIDTH-1:0]           mem_data,
  output logic                              inst_valid,
  input  logic                              inst_ready,
  output logic [4*DATA_WIDTH-1:0]           inst_data,
  output logic [ADDR_WIDTH-1:0]             inst_pc,
  output logic [$clog2(FQ_DEPTH+1)-1:0]     fq_count
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  fetch_state_t state;
  logic resp_pending;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [CW:0] occ;
  logic go;
  // both the request on the bus and the response due next edge still need a queue slot
  assign occ = (CW+1)'(fq_count) + (CW+1)'(mem_rd_en) + (CW+1)'(resp_pending);
  assign go = fetch_en && (occ < (CW+1)'(FQ_DEPTH));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      program_counter <= RESET_PC;
      mem_rd_en <= 1'b0;
      resp_pending <= 1'b0;
      resp_pc <= '0;
    end else if (redirect_valid) begin
      state <= fetch_en ? FETCH : STALL;
      program_counter <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      mem_rd_en <= 1'b0;
      resp_pending <= 1'b0;
    end else begin
      state <= state == IDLE ? (fetch_en ? FETCH : IDLE) : (go ? FETCH : STALL);
      mem_rd_en <= state != IDLE && go;
      program_counter <= mem_rd_en ? program_counter + ADDR_WIDTH'(4) : program_counter;
      resp_pending <= mem_rd_en;
      resp_pc <= program_counter;
    end
  end
  fetch_queue #(.AW(ADDR_WIDTH), .DW(4*DATA_WIDTH), .DEPTH(FQ_DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .clear(redirect_valid),
    .push(resp_pending),
    .push_pc(resp_pc),
    .push_data(mem_data),
    .pop(inst_valid && inst_ready),
    .valid(inst_valid),
    .head_pc(inst_pc),
    .head_data(inst_data),
    .count(fq_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests of fetch_unit against a 256-word synchronous instruction memory
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0, mem_data = '0;
  logic [31:0] program_counter, inst_data, inst_pc;
  logic mem_rd_en, inst_valid;
  logic [2:0] fq_count;
  logic [31:0] mem [256];
  logic [31:0] exp_pc;
  int total = 0, bad = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .program_counter(program_counter), .mem_rd_en(mem_rd_en),
    .mem_data(mem_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fq_count(fq_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_data <= mem[program_counter[9:2]];

  function automatic logic [31:0] wexp(input logic [31:0] pc);
    return {16'hC0DE, 6'd0, pc[9:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
    total++; if (program_counter !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", program_counter); end
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", mem_rd_en); end
    total++; if (fq_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fq_count); end
    total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", inst_data); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got=%h want=0", inst_pc); end
  endtask

  task automatic test_stream();
    int got = 0;
    rst = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1; exp_pc = 32'h0;
    for (int i = 0; i < 60 && got < 5; i++) begin
      if (inst_valid) begin
        total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL stream_pc got=%h want=%h", inst_pc, exp_pc); end
        total++; if (inst_data !== wexp(exp_pc)) begin bad++; $display("FAIL stream_data got=%h want=%h", inst_data, wexp(exp_pc)); end
        exp_pc += 4; got++;
      end
      step();
    end
    total++; if (got != 5) begin bad++; $display("FAIL stream_timeout got=%0d want=5", got); end
  endtask

  task automatic test_backpressure();
    int got = 0, maxc = 0;
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (int'(fq_count) > maxc) maxc = int'(fq_count);
    end
    total++; if (fq_count !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d want=4", fq_count); end
    total++; if (maxc != 4) begin bad++; $display("FAIL bp_max got=%0d want=4", maxc); end
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en got=%b want=0", mem_rd_en); end
    total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL bp_head got=%h want=%h", inst_pc, exp_pc); end
    inst_ready = 1'b1;
    for (int i = 0; i < 80 && got < 8; i++) begin
      if (inst_valid) begin
        total++; if (inst_pc !== exp_pc || inst_data !== wexp(exp_pc)) begin bad++; $display("FAIL bp_resume pc=%h data=%h want pc=%h", inst_pc, inst_data, exp_pc); end
        exp_pc += 4; got++;
      end
      step();
    end
    total++; if (got != 8) begin bad++; $display("FAIL bp_timeout got=%0d want=8", got); end
  endtask

  task automatic test_redirect();
    int got = 0;
    fetch_en = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) begin
        total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL rd_drain got=%h want=%h", inst_pc, exp_pc); end
        exp_pc += 4;
      end
      step();
    end
    fetch_en = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 20 && fq_count != 3'd3; i++) step();
    total++; if (fq_count !== 3'd3) begin bad++; $display("FAIL rd_fill got=%0d want=3", fq_count); end
    redirect_valid = 1'b1; redirect_pc = 32'h82;
    step();
    redirect_valid = 1'b0;
    total++; if (fq_count !== 3'd0) begin bad++; $display("FAIL rd_count got=%0d want=0", fq_count); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b want=0", inst_valid); end
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL rd_rd_en got=%b want=0", mem_rd_en); end
    total++; if (program_counter !== 32'h80) begin bad++; $display("FAIL rd_pc got=%h want=80", program_counter); end
    step();
    total++; if (mem_rd_en !== 1'b1 || program_counter !== 32'h80) begin bad++; $display("FAIL rd_first_req rd_en=%b pc=%h want 1 80", mem_rd_en, program_counter); end
    inst_ready = 1'b1; exp_pc = 32'h80;
    for (int i = 0; i < 40 && got < 3; i++) begin
      if (inst_valid) begin
        total++; if (inst_pc !== exp_pc || inst_data !== wexp(exp_pc)) begin bad++; $display("FAIL rd_seq pc=%h data=%h want pc=%h", inst_pc, inst_data, exp_pc); end
        exp_pc += 4; got++;
      end
      step();
    end
    total++; if (got != 3) begin bad++; $display("FAIL rd_timeout got=%0d want=3", got); end
  endtask

  task automatic test_redirect_pop();
    int got = 0, maxc = 0;
    inst_ready = 1'b1; fetch_en = 1'b1;
    for (int i = 0; i < 20 && !(inst_valid && mem_rd_en); i++) begin
      if (inst_valid) exp_pc += 4;
      step();
    end
    total++; if (!(inst_valid && mem_rd_en)) begin bad++; $display("FAIL rp_setup valid=%b rd_en=%b want 1 1", inst_valid, mem_rd_en); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    total++; if (fq_count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rp_clear count=%0d valid=%b want 0 0", fq_count, inst_valid); end
    exp_pc = 32'h80;
    for (int i = 0; i < 40 && got < 4; i++) begin
      if (int'(fq_count) > maxc) maxc = int'(fq_count);
      if (inst_valid) begin
        total++; if (inst_pc !== exp_pc || inst_data !== wexp(exp_pc)) begin bad++; $display("FAIL rp_seq pc=%h data=%h want pc=%h", inst_pc, inst_data, exp_pc); end
        exp_pc += 4; got++;
      end
      step();
    end
    total++; if (maxc > 1) begin bad++; $display("FAIL rp_max_count got=%0d want<=1", maxc); end
    total++; if (got != 4) begin bad++; $display("FAIL rp_timeout got=%0d want=4", got); end
  endtask

  task automatic test_toggle();
    int got = 0;
    logic have_last = 1'b0;
    logic [31:0] last = '0;
    inst_ready = 1'b1;
    for (int i = 0; i < 100 && got < 6; i++) begin
      if (mem_rd_en) begin
        if (have_last) begin
          total++; if (program_counter !== last + 32'd4) begin bad++; $display("FAIL tg_req got=%h want=%h", program_counter, last + 32'd4); end
        end
        last = program_counter; have_last = 1'b1;
      end
      if (inst_valid) begin
        total++; if (inst_pc !== exp_pc || inst_data !== wexp(exp_pc)) begin bad++; $display("FAIL tg_seq pc=%h data=%h want pc=%h", inst_pc, inst_data, exp_pc); end
        exp_pc += 4; got++;
      end
      fetch_en = ~fetch_en;
      step();
    end
    fetch_en = 1'b1;
    total++; if (got != 6) begin bad++; $display("FAIL tg_timeout got=%0d want=6", got); end
  endtask

  task automatic test_wrap();
    int got = 0;
    inst_ready = 1'b1; fetch_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0; exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 40 && got < 4; i++) begin
      if (inst_valid) begin
        total++; if (inst_pc !== exp_pc || inst_data !== wexp(exp_pc)) begin bad++; $display("FAIL wrap_seq pc=%h data=%h want pc=%h", inst_pc, inst_data, exp_pc); end
        exp_pc += 4; got++;
      end
      step();
    end
    total++; if (got != 4) begin bad++; $display("FAIL wrap_timeout got=%0d want=4", got); end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    for (int i = 0; i < 20 && !(inst_valid && mem_rd_en); i++) step();
    total++; if (!(inst_valid && mem_rd_en)) begin bad++; $display("FAIL rm_setup valid=%b rd_en=%b want 1 1", inst_valid, mem_rd_en); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", inst_valid); end
    total++; if (program_counter !== 32'h0) begin bad++; $display("FAIL rm_pc got=%h want=0", program_counter); end
    total++; if (mem_rd_en !== 1'b0 || fq_count !== 3'd0) begin bad++; $display("FAIL rm_idle rd_en=%b count=%0d want 0 0", mem_rd_en, fq_count); end
    step();
    total++; if (fq_count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rm_stale count=%0d valid=%b want 0 0", fq_count, inst_valid); end
    exp_pc = 32'h0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      if (inst_valid) begin
        total++; if (inst_pc !== exp_pc || inst_data !== wexp(exp_pc)) begin bad++; $display("FAIL rm_seq pc=%h data=%h want pc=%h", inst_pc, inst_data, exp_pc); end
        exp_pc += 4; got++;
      end
      step();
    end
    total++; if (got != 3) begin bad++; $display("FAIL rm_timeout got=%0d want=3", got); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 6'd0, i[7:0], 2'b00};
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_toggle();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
